pipe_stage_skid_reg: RTL and testbench
======================================

// Module: pipe_stage_skid_reg
// PURPOSE
//  Parametrised elastic pipeline-stage register for the superscalar datapath.
//  Carries LANES instruction slots between any two stages (EXE/MEM, MEM/WB, ...).
//  Uses a valid/ready handshake with a one-entry skid buffer, so a stall raised by
//  the downstream stage never needs a combinational path back to the upstream stage.
//  Provides per-lane valid bits, flush, bubble squashing and an occupancy count.
// PARAMETERS
//  LANES   2    number of issue slots carried in parallel (>=1)
//  DATA_W  107  payload bits per lane (mem_ctrl 4 + wb_ctrl 2 + aluout 32 +
//               writedata 32 + writereg 5 + upperimm 32)
//  SKID    1    1 = two-entry skid buffer with registered in_ready;
//               0 = single entry, in_ready combinational
// PORTS
//  clk            in   1              clock; all state updates on rising edge
//  reset          in   1              synchronous, active-high
//  flush          in   1              sync discard of all held groups
//  in_valid       in   1              upstream group valid
//  in_lane_valid  in   LANES          per-lane valid of incoming group
//  in_data        in   LANES*DATA_W   lane i at [i*DATA_W +: DATA_W]
//  in_ready       out  1              stage can accept a group this cycle
//  out_valid      out  1              held group presented downstream
//  out_lane_valid out  LANES          per-lane valid of presented group
//  out_data       out  LANES*DATA_W   presented payload
//  out_ready      in   1              downstream accepts presented group
//  occupancy      out  2              number of groups held (0..2)
// BEHAVIOUR
//  - accept = in_valid & in_ready; drain = out_valid & out_ready.
//  - Storage: main entry (drives out_*) and skid entry (SKID=1 only).
//  - State is EMPTY, ONE (main full) or TWO (main and skid full).
//  - out_valid = state!=EMPTY. SKID=1: in_ready = (state!=TWO), from a flop.
//  - SKID=0: in_ready = (state==EMPTY) | out_ready.
//  - EMPTY: accept -> ONE, main<=in.
//  - ONE: accept&!drain -> TWO, skid<=in. drain&!accept -> EMPTY.
//    accept&drain -> ONE, main<=in. Neither -> hold.
//  - TWO: drain -> ONE, main<=skid. No accept is possible, since in_ready=0.
//  - Latency: an accepted group appears on out_* the next cycle.
//  - Throughput: 1 group/cycle while out_ready=1.
//  - Bubble squash: accept with in_lane_valid==0 completes the handshake, stores
//    nothing and leaves state unchanged.
//  - Invalid lanes: payload of lanes with out_lane_valid[i]=0 reads as all zeros.
//  - Payload ordering is strict FIFO; a group is never duplicated or reordered.
//  - Priority: reset > flush > handshake.
//  - Flush: next state EMPTY, same-cycle input discarded, same-cycle drain still
//    counts on the downstream side. SKID=1: in_ready=1 on the cycle after flush.
//  - Reset (any cycle, including mid-transfer): next cycle out_valid=0,
//    out_lane_valid=0, out_data=0, occupancy=0, both entries cleared.
//    in_ready=1 (SKID=1: from the first cycle after reset deasserts).
//  - occupancy = 0/1/2 for EMPTY/ONE/TWO. With SKID=0 it never exceeds 1.
//  - No X leaves the block after reset, even if inputs are X while not accepted.
// TESTING
//  - Reset: reset=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0,
//    occupancy=0. First cycle after reset: in_ready=1.
//  - Streaming: out_ready=1, 8 back-to-back groups, lane0 data = 1..8 ->
//    out lane0 = 1..8 one cycle later each, occupancy stays 1, in_ready stays 1.
//  - Stall/skid (SKID=1): hold out_ready=0 and send A, B, C ->
//    A, B accepted, occupancy=2, in_ready=0, C waits.
//    Then release out_ready -> output order A, B, C with no loss or duplication.
//  - Lane mask: in_lane_valid=2'b10, lane0 data 0xDEAD ->
//    out_lane_valid=2'b10 and out lane0 payload=0. in_lane_valid=0 ->
//    handshake completes, occupancy unchanged.
//  - Flush: occupancy=2, assert flush with in_valid=1 and group D ->
//    next cycle occupancy=0, out_valid=0, D never appears.
//  - SKID=0: out_ready=0 while full -> in_ready=0. Raise out_ready ->
//    in_ready=1 in the same cycle, and a new group is accepted with the drain.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register: LANES slots per group, valid/ready handshake,
// optional one-entry skid buffer so downstream stalls never reach in_ready combinationally.

module pipe_stage_skid_lane #(
    parameter int DATA_W = 107
) (
    input  logic              lane_valid,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    assign q = lane_valid ? d : '0;
endmodule

module pipe_stage_skid_reg #(
    parameter int LANES  = 2,
    parameter int DATA_W = 107,
    parameter int SKID   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    out_ready,
    output logic [1:0]              occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t                  state, state_nxt;
    logic [LANES-1:0]        main_lv, skid_lv;
    logic [LANES*DATA_W-1:0] main_data, skid_data;
    logic                    accept, drain, wr;
    logic                    load_main_in, load_main_skid, load_skid;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;
    // An all-invalid group is a bubble: handshake completes but nothing is stored.
    assign wr     = accept & (|in_lane_valid);

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (wr) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
                ONE: begin
                    if (wr && !drain && SKID != 0) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (wr && drain) begin
                        load_main_in = 1'b1;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: if (drain) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            main_lv   <= '0;
            main_data <= '0;
            skid_lv   <= '0;
            skid_data <= '0;
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                main_lv   <= in_lane_valid;
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_lv   <= skid_lv;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_lv   <= in_lane_valid;
                skid_data <= in_data;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;
            always_ff @(posedge clk) begin
                if (reset) rdy_q <= 1'b1;
                else       rdy_q <= (state_nxt != TWO);
            end
            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign in_ready = (state == EMPTY) | out_ready;
        end
    endgenerate

    assign out_valid      = (state != EMPTY);
    assign occupancy      = state;
    // Stale entry contents never leak: lane valids gate on out_valid, payload on lane valid.
    assign out_lane_valid = out_valid ? main_lv : '0;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            pipe_stage_skid_lane #(.DATA_W(DATA_W)) u_lane (
                .lane_valid (out_lane_valid[i]),
                .d          (main_data[i*DATA_W +: DATA_W]),
                .q          (out_data[i*DATA_W +: DATA_W])
            );
        end
    endgenerate
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: SKID=1 and SKID=0 instances on shared stimulus,
// each compared every cycle against a queue-based model of the stage.

module tb_pipe_stage_skid_reg;
    localparam int L = 2;
    localparam int W = 107;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, flush, in_valid, out_ready;
    logic [L-1:0]   in_lv;
    logic [L*W-1:0] in_data;

    logic           rdy1, ov1, rdy0, ov0;
    logic [L-1:0]   olv1, olv0;
    logic [L*W-1:0] od1, od0;
    logic [1:0]     occ1, occ0;

    pipe_stage_skid_reg #(.LANES(L), .DATA_W(W), .SKID(1)) u_skid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_lane_valid(in_lv), .in_data(in_data), .in_ready(rdy1),
        .out_valid(ov1), .out_lane_valid(olv1), .out_data(od1),
        .out_ready(out_ready), .occupancy(occ1));

    pipe_stage_skid_reg #(.LANES(L), .DATA_W(W), .SKID(0)) u_noskid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_lane_valid(in_lv), .in_data(in_data), .in_ready(rdy0),
        .out_valid(ov0), .out_lane_valid(olv0), .out_data(od0),
        .out_ready(out_ready), .occupancy(occ0));

    typedef struct {
        logic [L-1:0]   lv;
        logic [L*W-1:0] d;
    } grp_t;

    grp_t          q1[$], q0[$];
    logic [W-1:0]  drained1[$];
    bit            known = 0;
    bit            last_acc1;
    int            checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [L*W-1:0] masked(input logic [L-1:0] lv, input logic [L*W-1:0] d);
        logic [L*W-1:0] r = '0;
        for (int i = 0; i < L; i++)
            if (lv[i]) r[i*W +: W] = d[i*W +: W];
        return r;
    endfunction

    function automatic logic [L*W-1:0] rand_data();
        logic [L*W-1:0] r;
        for (int i = 0; i < L*W; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic check_all();
        if (!known) return;
        chk("skid_in_ready", rdy1, q1.size() < 2);
        chk("skid_out_valid", ov1, q1.size() > 0);
        chk("skid_lane_valid", olv1, q1.size() > 0 ? q1[0].lv : '0);
        chk("skid_data", od1, q1.size() > 0 ? masked(q1[0].lv, q1[0].d) : '0);
        chk("skid_occ", occ1, q1.size());
        chk("noskid_in_ready", rdy0, (q0.size() == 0) || out_ready);
        chk("noskid_out_valid", ov0, q0.size() > 0);
        chk("noskid_lane_valid", olv0, q0.size() > 0 ? q0[0].lv : '0);
        chk("noskid_data", od0, q0.size() > 0 ? masked(q0[0].lv, q0[0].d) : '0);
        chk("noskid_occ", occ0, q0.size());
    endtask

    task automatic model_update();
        bit a1, d1, a0, d0;
        last_acc1 = 0;
        if (reset) begin
            q1.delete(); q0.delete(); known = 1;
        end else if (known) begin
            if (flush) begin
                q1.delete(); q0.delete();
            end else begin
                a1 = in_valid && (q1.size() < 2);
                d1 = out_ready && (q1.size() > 0);
                a0 = in_valid && ((q0.size() == 0) || out_ready);
                d0 = out_ready && (q0.size() > 0);
                last_acc1 = a1;
                if (d1) void'(q1.pop_front());
                if (a1 && in_lv != '0) q1.push_back('{lv: in_lv, d: in_data});
                if (d0) void'(q0.pop_front());
                if (a0 && in_lv != '0) q0.push_back('{lv: in_lv, d: in_data});
            end
        end
    endtask

    // Inputs are set after the falling edge; outputs checked before the rising edge.
    task automatic cycle();
        #1;
        check_all();
        if (known && ov1 && out_ready) drained1.push_back(od1[W-1:0]);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic send0(input logic [W-1:0] v);
        in_valid = 1'b1;
        in_lv    = 2'b11;
        in_data  = rand_data();
        in_data[W-1:0] = v;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_lv = 2'b11; in_data = rand_data();
        @(negedge clk);

        // reset held two cycles with a valid group on the input
        repeat (2) cycle();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", rdy1, 1'b1);
        chk("rst_out_valid", ov1, 1'b0);
        chk("rst_out_data", od1, '0);
        chk("rst_occ", occ1, 2'd0);

        // streaming, one group per cycle
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            send0(W'(k));
            cycle();
            chk("stream_lane0", od1[W-1:0], W'(k));
            chk("stream_occ", occ1, 2'd1);
        end
        in_valid = 1'b0;
        repeat (2) cycle();

        // lane mask and bubble squash
        send0(W'(16'hDEAD));
        in_lv = 2'b10;
        cycle();
        chk("mask_lane_valid", olv1, 2'b10);
        chk("mask_lane0_zero", od1[W-1:0], '0);
        out_ready = 1'b0;
        in_lv = 2'b00;
        #1 chk("bubble_ready", rdy1, 1'b1);
        cycle();
        chk("bubble_occ", occ1, 2'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) cycle();

        // stall: A, B fill both entries, C waits, then drains in order
        out_ready = 1'b0;
        send0(W'(10)); cycle();
        send0(W'(11)); cycle();
        chk("stall_occ", occ1, 2'd2);
        chk("stall_in_ready", rdy1, 1'b0);
        send0(W'(12));
        repeat (2) cycle();
        drained1.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 5 && in_valid; n++) begin
            cycle();
            if (last_acc1) in_valid = 1'b0;
        end
        chk("stall_c_accepted", in_valid, 1'b0);
        repeat (3) cycle();
        chk("stall_drain_cnt", drained1.size(), 3);
        if (drained1.size() == 3) begin
            chk("stall_order_a", drained1[0], W'(10));
            chk("stall_order_b", drained1[1], W'(11));
            chk("stall_order_c", drained1[2], W'(12));
        end

        // flush with both entries full and a group D on the input
        out_ready = 1'b0;
        send0(W'(20)); cycle();
        send0(W'(21)); cycle();
        chk("pre_flush_occ", occ1, 2'd2);
        send0(W'(16'hD00D));
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_occ", occ1, 2'd0);
        chk("flush_out_valid", ov1, 1'b0);
        chk("flush_in_ready", rdy1, 1'b1);
        drained1.delete();
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("flush_no_d", drained1.size(), 0);

        // SKID=0: ready follows out_ready combinationally while full
        out_ready = 1'b0;
        send0(W'(16'h11)); cycle();
        send0(W'(16'h22));
        #1 chk("noskid_stall_rdy", rdy0, 1'b0);
        out_ready = 1'b1;
        #1 chk("noskid_release_rdy", rdy0, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("noskid_new_lane0", od0[W-1:0], W'(16'h22));
        chk("noskid_occ", occ0, 2'd1);
        repeat (2) cycle();

        // randomized traffic, with X on the inputs whenever nothing is offered
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 79) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            in_valid  = ($urandom_range(0, 9) < 7);
            if (in_valid) begin
                in_lv   = L'($urandom_range(0, 3));
                in_data = rand_data();
            end else begin
                in_lv   = 'x;
                in_data = 'x;
            end
            cycle();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
